// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse playback sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT  = 2'b00,
    SYM_DASH = 2'b01,
    SYM_CGAP = 2'b10,
    SYM_WGAP = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MARK,
    ST_SPACE
  } state_t;

  localparam int DEF_DEPTH          = 16;
  localparam int DEF_DOT_UNITS      = 1;
  localparam int DEF_DASH_UNITS     = 3;
  localparam int DEF_ELEM_GAP_UNITS = 1;
  localparam int DEF_CHAR_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS = 7;
  localparam int DEF_CNT_W          = 3;

endpackage

// File: rtl/morse_sym_fifo.sv
// 2-bit symbol queue with flush; MORSE_LOOP_EN adds a non-destructive play pointer
// so the stored entries can be replayed without being consumed.
module morse_sym_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [1:0]               push_dat,
  input  logic                     pop,
  input  logic                     flush,
`ifdef MORSE_LOOP_EN
  input  logic                     rewind,
`endif
  output logic [1:0]               rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic                     avail,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          pop_head;

  assign count   = cnt;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

`ifdef MORSE_LOOP_EN
  logic [AW-1:0] play_ptr;
  logic [AW:0]   play_left;

  // Entries are never consumed in loop mode; only clear/rst discards them.
  assign pop_head = 1'b0;
  assign rd_dat   = mem[play_ptr];
  assign avail    = (play_left != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      play_ptr  <= '0;
      play_left <= '0;
    end else if (flush) begin
      play_ptr  <= '0;
      play_left <= '0;
    end else if (rewind) begin
      play_ptr  <= rd_ptr;
      play_left <= cnt;
    end else if (pop && avail) begin
      play_ptr  <= play_ptr + AW'(1);
      play_left <= play_left - CNT_ONE;
    end
  end
`else
  assign pop_head = pop && !empty;
  assign rd_dat   = mem[rd_ptr];
  assign avail    = !empty;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_head) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop_head})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/morse_play_ctrl.sv
// Queues Morse symbols and plays them on the LED, timed in tick units.
// MORSE_LOOP_EN: repeat the stored message until a second play or clear.
module morse_play_ctrl
  import morse_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int DOT_UNITS      = DEF_DOT_UNITS,
  parameter int DASH_UNITS     = DEF_DASH_UNITS,
  parameter int ELEM_GAP_UNITS = DEF_ELEM_GAP_UNITS,
  parameter int CHAR_GAP_UNITS = DEF_CHAR_GAP_UNITS,
  parameter int WORD_GAP_UNITS = DEF_WORD_GAP_UNITS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sym_valid,
  input  logic [1:0] sym_code,
  output logic       sym_ready,
  input  logic       play,
  input  logic       clear,
  output logic       led,
  output logic       busy,
  output logic       green,
  output logic       red
);

  localparam int AW = $clog2(DEPTH);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             red_q;
  logic             done_q;
  logic             full, empty, avail;
  logic             wr_en, pop, last;
  logic [1:0]       head_dat;
  logic [AW:0]      fifo_count;

`ifdef MORSE_LOOP_EN
  logic stop_q, stop_d;
  logic wrap_q, wrap_d;
  logic rewind;

  // The stored message is frozen while it is being replayed.
  assign sym_ready = !full && (state == ST_IDLE);
`else
  assign sym_ready = !full;
`endif

  assign wr_en = sym_valid && sym_ready && !clear;
  assign pop   = (state == ST_FETCH);
  // Saturating compare: a counter already at 0 still ends on the next tick.
  assign last  = (cnt_q <= CNT_W'(1));

  assign led   = (state == ST_MARK);
  assign busy  = (state != ST_IDLE);
  assign green = (state == ST_IDLE) && (empty || done_q);
  assign red   = red_q;

  morse_sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .push_dat (sym_code),
    .pop      (pop),
    .flush    (clear),
`ifdef MORSE_LOOP_EN
    .rewind   (rewind),
`endif
    .rd_dat   (head_dat),
    .full     (full),
    .empty    (empty),
    .avail    (avail),
    .count    (fifo_count)
  );

  always_comb begin
    nxt   = state;
    cnt_d = cnt_q;
`ifdef MORSE_LOOP_EN
    rewind = 1'b0;
    stop_d = stop_q;
    wrap_d = wrap_q;
    if (play && state != ST_IDLE) stop_d = 1'b1;
`endif
    unique case (state)
      ST_IDLE: begin
        if (play && fifo_count != '0) begin
          nxt = ST_FETCH;
`ifdef MORSE_LOOP_EN
          rewind = 1'b1;
          stop_d = 1'b0;
          wrap_d = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        unique case (sym_t'(head_dat))
          SYM_DOT:  begin cnt_d = CNT_W'(DOT_UNITS);      nxt = ST_MARK;  end
          SYM_DASH: begin cnt_d = CNT_W'(DASH_UNITS);     nxt = ST_MARK;  end
          SYM_CGAP: begin cnt_d = CNT_W'(CHAR_GAP_UNITS); nxt = ST_SPACE; end
          SYM_WGAP: begin cnt_d = CNT_W'(WORD_GAP_UNITS); nxt = ST_SPACE; end
        endcase
      end
      ST_MARK: begin
        if (tick) begin
          if (last) begin
            cnt_d = CNT_W'(ELEM_GAP_UNITS);
            nxt   = ST_SPACE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_SPACE: begin
        if (tick) begin
          if (!last) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
`ifdef MORSE_LOOP_EN
            if (stop_q) begin
              nxt = ST_IDLE;
            end else if (wrap_q) begin
              rewind = 1'b1;
              wrap_d = 1'b0;
              nxt    = ST_FETCH;
            end else if (avail) begin
              nxt = ST_FETCH;
            end else begin
              // End of pass: hold a word gap of silence before restarting.
              cnt_d  = CNT_W'(WORD_GAP_UNITS);
              wrap_d = 1'b1;
            end
`else
            nxt = avail ? ST_FETCH : ST_IDLE;
`endif
          end
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt_q  <= '0;
      red_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef MORSE_LOOP_EN
      stop_q <= 1'b0;
      wrap_q <= 1'b0;
`endif
    end else if (clear) begin
      state  <= ST_IDLE;
      cnt_q  <= '0;
      red_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef MORSE_LOOP_EN
      stop_q <= 1'b0;
      wrap_q <= 1'b0;
`endif
    end else begin
      state  <= nxt;
      cnt_q  <= cnt_d;
      done_q <= (state == ST_SPACE) && (nxt == ST_IDLE);
      if (sym_valid && full) red_q <= 1'b1;
`ifdef MORSE_LOOP_EN
      stop_q <= stop_d;
      wrap_q <= wrap_d;
`endif
    end
  end

endmodule

// File: tb/tb_morse_play_ctrl.sv
// Directed-plus-random bench: LED level sampled on every tick is compared with
// a symbol-to-units expansion of the pushed message.
module tb_morse_play_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, sym_valid, play, clear;
  logic [1:0] sym_code;
  logic       sym_ready, led, busy, green, red;

  int checks = 0;
  int failures = 0;
  int tick_p = 4;
  int phase = 0;
  bit tick_en = 1'b1;
  bit got[$];
  bit exp_q[$];

  morse_play_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_ready(sym_ready), .play(play), .clear(clear), .led(led), .busy(busy),
    .green(green), .red(red)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance one clock; one-shot inputs drop and the tick pattern advances.
  task automatic step();
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    play      = 1'b0;
    clear     = 1'b0;
    phase     = (phase + 1) % tick_p;
    tick      = tick_en && (phase == 0);
  endtask

  task automatic push(input logic [1:0] c);
    sym_valid = 1'b1;
    sym_code  = c;
    step();
  endtask

  // Each symbol becomes its LED level for every unit it occupies.
  function automatic void model_add(input logic [1:0] s);
    int on_u, off_u;
    case (s)
      2'd0:    begin on_u = 1; off_u = 1; end
      2'd1:    begin on_u = 3; off_u = 1; end
      2'd2:    begin on_u = 0; off_u = 3; end
      default: begin on_u = 0; off_u = 7; end
    endcase
    repeat (on_u)  exp_q.push_back(1'b1);
    repeat (off_u) exp_q.push_back(1'b0);
  endfunction

  task automatic push_random(input int n);
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      c = 2'($urandom_range(0, 3));
      push(c);
      model_add(c);
    end
  endtask

  // Play is issued the cycle after a tick so the FETCH cycle never holds a tick.
  task automatic start_play();
    int w = 0;
    while (tick !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    if (w >= 20) chk("tick_wait", 0, 1);
    step();
    play = 1'b1;
    step();
  endtask

  task automatic capture(input int inject_at);
    int  c = 0;
    bit  inj = 1'b0;
    got.delete();
    while (busy === 1'b1 && c < 5000) begin
      if (tick === 1'b1) got.push_back(led);
      if (!inj && got.size() == inject_at) begin
        sym_valid = 1'b1;
        sym_code  = 2'd0;
        inj       = 1'b1;
      end
      step();
      c++;
    end
    if (c >= 5000) chk("capture_timeout", 0, 1);
  endtask

  task automatic compare_run(input string tag);
    int bad = 0;
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_done_green"}, green, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int ia;
    rst = 1'b1; tick = 1'b0; sym_valid = 1'b0; play = 1'b0; clear = 1'b0; sym_code = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_red", red, 0);
    chk("rst_green", green, 1);
    chk("rst_ready", sym_ready, 1);
    rst = 1'b0;
    step();

    // dot, dash with a tick every 4 clocks; led rises 2 clocks after play
    tick_p = 4;
    exp_q.delete();
    push(2'd0); model_add(2'd0);
    push(2'd1); model_add(2'd1);
    start_play();
    chk("fetch_busy", busy, 1);
    chk("fetch_led", led, 0);
    step();
    chk("play_to_led_2clk", led, 1);
    capture(-1);
    compare_run("dot_dash");

    tick_p = $urandom_range(3, 6);
    exp_q.delete();
    push(2'd1); model_add(2'd1);
    push(2'd2); model_add(2'd2);
    push(2'd0); model_add(2'd0);
    start_play();
    capture(-1);
    compare_run("dash_cgap_dot");
    repeat (3) step();
    chk("after_run_empty_green", green, 1);
    chk("after_run_ready", sym_ready, 1);

    for (int r = 0; r < 3; r++) begin
      tick_p = $urandom_range(3, 6);
      exp_q.delete();
      push_random($urandom_range(1, 8));
      start_play();
      capture(-1);
      compare_run("random_msg");
    end

    // a dot written during the final SPACE extends the same run
    tick_p = $urandom_range(3, 6);
    exp_q.delete();
    push_random($urandom_range(1, 4));
    ia = exp_q.size() - 1;
    model_add(2'd0);
    start_play();
    capture(ia);
    compare_run("late_push");

    // 16 fit, the 17th is dropped and flags overflow
    tick_p = 3;
    exp_q.delete();
    push_random(16);
    chk("full_not_ready", sym_ready, 0);
    chk("full_red_clear", red, 0);
    push(2'd1);
    chk("overflow_red", red, 1);
    start_play();
    capture(-1);
    compare_run("overflow16");
    chk("red_sticky", red, 1);
    clear = 1'b1;
    step();
    chk("clear_red", red, 0);

    // a write alongside clear is discarded
    sym_valid = 1'b1; sym_code = 2'd1; clear = 1'b1;
    step();
    chk("clear_drop_green", green, 1);
    start_play();
    chk("clear_drop_no_play", busy, 0);

    // clear during MARK stops playback at once
    push(2'd1);
    start_play();
    step();
    chk("pre_clear_led", led, 1);
    clear = 1'b1;
    step();
    chk("clear_led", led, 0);
    chk("clear_busy", busy, 0);
    chk("clear_green", green, 1);

    // asynchronous reset during MARK
    push(2'd1);
    push(2'd0);
    start_play();
    step();
    chk("pre_rst_led", led, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("post_rst_green", green, 1);
    chk("post_rst_ready", sym_ready, 1);
    start_play();
    chk("post_rst_play_ignored", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
